// File: rtl/mannix_mem_line_packer_pkg.sv
// Shared types and helpers for the Mannix DDR-to-SRAM line packer.
// Holds the FSM state enum and the last-beat byte mask function.
package mannix_mem_pkg;

  localparam int MASK_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } mem_pack_state_e;

  // Low nbytes bits set; zero means a full beat.
  function automatic logic [MASK_W-1:0] byte_mask(
    input int unsigned nbytes,
    input int unsigned nbt
  );
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (i < nbt && (nbytes == 0 || i < nbytes)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/mannix_mem_line_packer_if.sv
// DDR read-beat stream and SRAM line-write bus of the line packer.
// master: DDR client plus SRAM controller side; slave: the packer.
interface mannix_mem_line_packer_if #(
  parameter int DDR_W  = 64,
  parameter int BEATS  = 4,
  parameter int ADDR_W = 19
);
  localparam int LINE_W = DDR_W * BEATS;
  localparam int NB_W   = $clog2(DDR_W / 8) + 1;

  logic [DDR_W-1:0]    ddr_data;
  logic                ddr_valid;
  logic                ddr_last;
  logic [NB_W-1:0]     ddr_last_bytes;
  logic                ddr_ready;
  logic                sram_we;
  logic [ADDR_W-1:0]   sram_addr;
  logic [LINE_W-1:0]   sram_wdata;
  logic [LINE_W/8-1:0] sram_be;
  logic                sram_ready;

  modport master (
    output ddr_data, ddr_valid, ddr_last,
    output ddr_last_bytes, sram_ready,
    input  ddr_ready, sram_we, sram_addr,
    input  sram_wdata, sram_be
  );

  modport slave (
    input  ddr_data, ddr_valid, ddr_last,
    input  ddr_last_bytes, sram_ready,
    output ddr_ready, sram_we, sram_addr,
    output sram_wdata, sram_be
  );

endinterface

// File: rtl/mannix_mem_line_buf.sv
// Single SRAM line buffer: masked slot writes, byte-enable accumulation
// and clear; bytes outside the mask are stored as zero.
module mannix_mem_line_buf #(
  parameter int DDR_W = 64,
  parameter int BEATS = 4,
  parameter int IDX_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      wr,
  input  logic [IDX_W-1:0]          idx,
  input  logic [DDR_W-1:0]          data,
  input  logic [DDR_W/8-1:0]        mask,
  output logic [DDR_W*BEATS-1:0]    line,
  output logic [DDR_W*BEATS/8-1:0]  be
);
  localparam int BB = DDR_W / 8;

  logic [DDR_W-1:0] masked;

  always_comb begin
    masked = '0;
    for (int i = 0; i < BB; i++) begin
      if (mask[i]) masked[i*8 +: 8] = data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      line <= '0;
      be   <= '0;
    end else if (wr) begin
      for (int s = 0; s < BEATS; s++) begin
        if (idx == IDX_W'(s)) begin
          line[s*DDR_W +: DDR_W] <= masked;
          be[s*BB +: BB]         <= mask;
        end
      end
    end
  end

endmodule

// File: rtl/mannix_mem_line_packer.sv
// Packs BEATS DDR read beats into one SRAM line and writes lines to
// consecutive addresses from a programmed base; single buffer, no overlap.
module mannix_mem_line_packer
  import mannix_mem_pkg::*;
#(
  parameter int DDR_W  = 64,
  parameter int BEATS  = 4,
  parameter int ADDR_W = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  mannix_mem_line_packer_if.slave bus,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       line_cnt
);
  localparam int BB    = DDR_W / 8;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  mem_pack_state_e state, next;

  logic [IDX_W-1:0]  beat_idx;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;
  logic              acc;
  logic              line_end;
  logic              clr;
  logic [MASK_W-1:0] full_mask;
  logic [BB-1:0]     beat_mask;

  assign acc      = (state == FILL) && bus.ddr_valid;
  assign line_end = (beat_idx == IDX_W'(BEATS - 1)) || bus.ddr_last;

  always_comb begin
    full_mask = byte_mask(
      bus.ddr_last ? 32'(bus.ddr_last_bytes) : 32'd0, BB);
    beat_mask = full_mask[BB-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next          = state;
    bus.ddr_ready = 1'b0;
    bus.sram_we   = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    clr           = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          next = FILL;
          clr  = 1'b1;
        end
      end
      FILL: begin
        bus.ddr_ready = 1'b1;
        busy          = 1'b1;
        if (acc && line_end) next = WRITE;
      end
      WRITE: begin
        bus.sram_we = 1'b1;
        busy        = 1'b1;
        if (bus.sram_ready) begin
          clr  = 1'b1;
          next = last_q ? DONE : FILL;
        end
      end
      DONE: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      beat_idx <= '0;
      line_cnt <= '0;
      last_q   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        addr_q   <= base_addr;
        beat_idx <= '0;
        line_cnt <= '0;
        last_q   <= 1'b0;
      end
      if (acc) begin
        beat_idx <= beat_idx + 1'b1;
        if (line_end) last_q <= bus.ddr_last;
      end
      if (state == WRITE && bus.sram_ready) begin
        addr_q   <= addr_q + 1'b1;
        line_cnt <= line_cnt + 1'b1;
        beat_idx <= '0;
      end
    end
  end

  assign bus.sram_addr = addr_q;

  mannix_mem_line_buf #(
    .DDR_W (DDR_W),
    .BEATS (BEATS),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .wr   (acc),
    .idx  (beat_idx),
    .data (bus.ddr_data),
    .mask (beat_mask),
    .line (bus.sram_wdata),
    .be   (bus.sram_be)
  );

endmodule

// File: tb/tb_mannix_mem_line_packer.sv
// Directed bench for mannix_mem_line_packer (DDR_W=64, BEATS=4, ADDR_W=19).
// Lines are compared against a byte-level model built from the beat pattern.
module tb_mannix_mem_line_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [18:0] base_addr = '0;
  logic        busy;
  logic        done;
  logic [18:0] line_cnt;

  int checks = 0;
  int failures = 0;

  mannix_mem_line_packer_if #(.DDR_W(64), .BEATS(4), .ADDR_W(19)) bus ();

  mannix_mem_line_packer #(.DDR_W(64), .BEATS(4), .ADDR_W(19)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .line_cnt  (line_cnt)
  );

  always #5 clk = ~clk;

  logic [18:0]  wa_q[$];
  logic [255:0] wd_q[$];
  logic [31:0]  wb_q[$];
  int mcyc = 0;
  int last_w_cyc = -10;
  int last_d_cyc = -20;

  always @(posedge clk) begin
    mcyc <= mcyc + 1;
    if (!rst && bus.sram_we && bus.sram_ready) begin
      wa_q.push_back(bus.sram_addr);
      wd_q.push_back(bus.sram_wdata);
      wb_q.push_back(bus.sram_be);
      last_w_cyc <= mcyc;
    end
    if (!rst && done) last_d_cyc <= mcyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bd(input int i);
    return 64'hA5C3_96F0_1E2D_3C00 | 64'(i);
  endfunction

  task automatic exp_line(input int l, input int n, input logic [3:0] lb,
                          output logic [255:0] w, output logic [31:0] be);
    logic [7:0]  m;
    logic [63:0] d;
    int b;
    w  = '0;
    be = '0;
    for (int s = 0; s < 4; s++) begin
      b = l * 4 + s;
      if (b < n) begin
        m = (b == n - 1 && lb != 0) ? 8'((1 << lb) - 1) : 8'hFF;
        d = bd(b);
        for (int k = 0; k < 8; k++)
          if (m[k]) w[s*64 + k*8 +: 8] = d[k*8 +: 8];
        be[s*8 +: 8] = m;
      end
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last,
                           input logic [3:0] lb);
    int n = 0;
    bus.ddr_data       = d;
    bus.ddr_valid      = 1'b1;
    bus.ddr_last       = last;
    bus.ddr_last_bytes = lb;
    while (!bus.ddr_ready && n < 50) begin
      tick();
      n++;
    end
    chk("beat_ready", 256'(bus.ddr_ready), 256'(1'b1));
    tick();
    bus.ddr_valid = 1'b0;
    bus.ddr_last  = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_ddr_ready", 256'(bus.ddr_ready), 256'(0));
    chk("rst_sram_we", 256'(bus.sram_we), 256'(0));
    chk("rst_sram_addr", 256'(bus.sram_addr), 256'(0));
    chk("rst_sram_wdata", bus.sram_wdata, 256'(0));
    chk("rst_sram_be", 256'(bus.sram_be), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_line_cnt", 256'(line_cnt), 256'(0));
  endtask

  task automatic run_xfer(input logic [18:0] base, input int n,
                          input logic [3:0] lb, input int stall,
                          input bit glitch);
    int nl;
    int k;
    logic [255:0] w;
    logic [31:0]  be;
    logic [18:0]  ea;
    nl = (n + 3) / 4;
    wa_q.delete();
    wd_q.delete();
    wb_q.delete();
    bus.sram_ready = (stall == 0);
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = 19'h0;
    chk("start_busy", 256'(busy), 256'(1));
    for (int b = 0; b < n; b++) begin
      if (b == 4 && stall > 0) begin
        exp_line(0, n, lb, w, be);
        bus.ddr_data       = bd(b);
        bus.ddr_valid      = 1'b1;
        bus.ddr_last       = (b == n - 1);
        bus.ddr_last_bytes = lb;
        for (int c = 0; c < stall; c++) begin
          chk("stall_we", 256'(bus.sram_we), 256'(1));
          chk("stall_addr", 256'(bus.sram_addr), 256'(base));
          chk("stall_wdata", bus.sram_wdata, w);
          chk("stall_ddr_ready", 256'(bus.ddr_ready), 256'(0));
          tick();
        end
        bus.sram_ready = 1'b1;
      end
      if (b == 1 && glitch) begin
        start = 1'b1;
        base_addr = 19'h555;
      end
      send_beat(bd(b), b == n - 1, lb);
      start = 1'b0;
      base_addr = 19'h0;
    end
    k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    chk("done_seen", 256'(done), 256'(1));
    chk("done_busy", 256'(busy), 256'(0));
    chk("line_cnt", 256'(line_cnt), 256'(nl));
    chk("num_lines", 256'(wa_q.size()), 256'(nl));
    for (int l = 0; l < nl; l++) begin
      if (l < wa_q.size()) begin
        exp_line(l, n, lb, w, be);
        ea = base + 19'(l);
        chk($sformatf("addr_l%0d", l), 256'(wa_q[l]), 256'(ea));
        chk($sformatf("wdata_l%0d", l), wd_q[l], w);
        chk($sformatf("be_l%0d", l), 256'(wb_q[l]), 256'(be));
      end
    end
    tick();
    chk("done_pulse", 256'(done), 256'(0));
    chk("done_after_write", 256'(last_d_cyc), 256'(last_w_cyc + 1));
    chk("idle_ddr_ready", 256'(bus.ddr_ready), 256'(0));
  endtask

  initial begin
    bus.ddr_data       = '0;
    bus.ddr_valid      = 1'b0;
    bus.ddr_last       = 1'b0;
    bus.ddr_last_bytes = '0;
    bus.sram_ready     = 1'b1;
    tick();
    tick();
    chk_reset_vals();
    rst = 1'b0;
    tick();

    run_xfer(19'h00100, 8, 4'd0, 0, 1'b0);
    run_xfer(19'h00200, 6, 4'd3, 0, 1'b0);
    run_xfer(19'h00300, 8, 4'd0, 5, 1'b0);
    run_xfer(19'h7FFFF, 8, 4'd0, 0, 1'b0);

    wa_q.delete();
    base_addr = 19'h40;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_beat(bd(0), 1'b0, 4'd0);
    send_beat(bd(1), 1'b0, 4'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals();
    tick();
    tick();
    chk("rst_no_write", 256'(wa_q.size()), 256'(0));
    run_xfer(19'h00020, 8, 4'd0, 0, 1'b0);

    bus.ddr_valid = 1'b1;
    bus.ddr_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      chk("idle_valid_ignored", 256'(bus.ddr_ready), 256'(0));
      tick();
    end
    bus.ddr_valid = 1'b0;
    run_xfer(19'h00400, 8, 4'd0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
